alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width taken from src2[SHW-1:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  unit accepts request this cycle.
REQ-007 src1  input  XLEN  operand A.
REQ-008 src2  input  XLEN  operand B.
REQ-009 alu_control  input  4  operation select.
REQ-010 out_valid  output  1  result/zero/err valid.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 result  output  XLEN  registered result.
REQ-013 zero  output  1  high when result == 0.
REQ-014 err  output  1  high when accepted alu_control was illegal.

Function
REQ-015 Request accepted on a rising edge with in_valid && in_ready; src1, src2, alu_control captured at that edge; inputs ignored otherwise.
REQ-016 Encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT signed, 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU, 1010 MUL low XLEN bits, 1011 DIVU, 1100 REMU; 1101-1111 illegal.
REQ-017 ADD/SUB wrap modulo 2^XLEN; no carry/overflow output.
REQ-018 SLT/SLTU result is XLEN-bit 0 or 1.
REQ-019 SRA replicates src1[XLEN-1]; shift amount 0 returns src1 unchanged.
REQ-020 Illegal op: result 0, zero 1, err 1, single-cycle latency.
REQ-021 FSM states IDLE, BUSY, DONE.
REQ-022 IDLE: in_ready 1; accept of single-cycle op (0000-1001, illegal) -> DONE with result registered; out_valid high in the cycle after acceptance (latency 1).
REQ-023 IDLE: accept of MUL/DIVU/REMU -> BUSY, iteration counter loaded with XLEN.
REQ-024 BUSY: in_ready 0; MUL = shift-add, one multiplier bit per cycle; DIVU/REMU = restoring division, one quotient bit per cycle; counter decrements each cycle; at counter 1 -> DONE; out_valid high exactly XLEN+1 cycles after acceptance.
REQ-025 DIVU with src2 == 0: quotient all ones; REMU with src2 == 0: remainder = src1; same XLEN+1 latency.
REQ-026 DONE: out_valid 1; result, zero, err held stable until out_ready.
REQ-027 DONE with out_ready 0: in_ready 0, no state change (backpressure, unlimited).
REQ-028 DONE with out_ready 1: in_ready 1; new request in same cycle accepted -> next state per REQ-022/023; no request -> IDLE.
REQ-029 Back-to-back single-cycle ops with out_ready held 1 sustain one result per cycle.
REQ-030 zero and err are registered with result, never combinational from inputs.
REQ-031 out_valid never asserted without a corresponding accepted request; exactly one result per accepted request.

Reset
REQ-032 rst_n low asynchronously forces state IDLE, out_valid 0, result 0, zero 1, err 0, counter 0, internal operand/accumulator registers 0.
REQ-033 in_ready 0 while rst_n low; 1 from first clock edge after rst_n deasserts.
REQ-034 Reset during BUSY or DONE abandons the operation; no result is ever delivered for it.

Verification (XLEN=32)
REQ-035 ADD 0xFFFFFFFF+0x00000001, out_ready 1 -> out_valid next cycle, result 0, zero 1, err 0.
REQ-036 SLT 0x80000000,0x00000001 -> 1; SLTU same operands -> 0; SRA 0x80000000 by 4 -> 0xF8000000; SRL same -> 0x08000000.
REQ-037 MUL 0x00010001 x 0x00010001 -> result 0x00020001, out_valid exactly 33 cycles after accept, in_ready 0 throughout BUSY.
REQ-038 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
REQ-039 Illegal op 1111 with out_ready 0 for 5 cycles -> result 0, err 1 held stable, in_ready 0; then out_ready 1 with new ADD 2+3 same cycle -> next result 5.
REQ-040 rst_n pulsed low mid-DIVU (cycle 10) -> out_valid 0 immediately, no result after release, next ADD 1+1 -> 2 with latency 1.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU behind valid/ready handshakes.
// Simple ops finish in one clock; MUL/DIVU/REMU iterate one bit per clock.
module alu_mc #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [3:0]      alu_control,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            err
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic            alive_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;

  logic            accept;
  logic            is_multi;
  logic            last;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] sc_res;
  logic            sc_err;
  logic [XLEN-1:0] mul_acc, mul_mc, mul_mp;
  logic [XLEN:0]   div_sh, div_trial;
  logic [XLEN-1:0] div_rem, div_quo;
  logic [XLEN-1:0] fin_res;

  assign shamt    = src2[SHW-1:0];
  assign accept   = in_valid & in_ready;
  assign is_multi = (alu_control == OP_MUL) ||
                    (alu_control == OP_DIVU) ||
                    (alu_control == OP_REMU);
  assign last     = (state_q == BUSY) && (cnt_q == CW'(1));

  // State register; alive_q holds in_ready low until the first edge out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = is_multi ? BUSY : DONE;
      BUSY: if (cnt_q == CW'(1)) state_d = DONE;
      DONE: begin
        if (out_ready) begin
          if (accept) state_d = is_multi ? BUSY : DONE;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and result outputs
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = alive_q;
      DONE:    in_ready = alive_q & out_ready;
      default: in_ready = 1'b0;
    endcase
    out_valid = (state_q == DONE);
    result    = result_q;
    zero      = zero_q;
    err       = err_q;
  end

  // Single-cycle operation decode
  always_comb begin
    sc_res = '0;
    sc_err = 1'b0;
    case (alu_control)
      OP_ADD:  sc_res = src1 + src2;
      OP_SUB:  sc_res = src1 - src2;
      OP_AND:  sc_res = src1 & src2;
      OP_OR:   sc_res = src1 | src2;
      OP_XOR:  sc_res = src1 ^ src2;
      OP_SLT:  sc_res = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      OP_SLL:  sc_res = src1 << shamt;
      OP_SRL:  sc_res = src1 >> shamt;
      OP_SRA:  sc_res = $signed(src1) >>> shamt;
      OP_SLTU: sc_res = {{(XLEN-1){1'b0}}, (src1 < src2)};
      OP_MUL, OP_DIVU, OP_REMU: sc_res = '0;
      default: sc_err = 1'b1;
    endcase
  end

  // One shift-add step and one restoring-division step per clock
  always_comb begin
    mul_acc   = opb_q[0] ? (acc_q + opa_q) : acc_q;
    mul_mc    = opa_q << 1;
    mul_mp    = opb_q >> 1;
    div_sh    = {acc_q, opa_q[XLEN-1]};
    div_trial = div_sh - {1'b0, opb_q};
    if (!div_trial[XLEN]) begin
      div_rem = div_trial[XLEN-1:0];
      div_quo = {opa_q[XLEN-2:0], 1'b1};
    end else begin
      div_rem = div_sh[XLEN-1:0];
      div_quo = {opa_q[XLEN-2:0], 1'b0};
    end
    if (op_q == OP_MUL)       fin_res = mul_acc;
    else if (op_q == OP_DIVU) fin_res = div_quo;
    else                      fin_res = div_rem;
  end

  // Datapath next-state: capture on accept, iterate while busy
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    if (accept) begin
      op_d = alu_control;
      if (is_multi) begin
        cnt_d = CW'(XLEN);
        acc_d = '0;
        opa_d = src1;
        opb_d = src2;
      end else begin
        result_d = sc_res;
        zero_d   = (sc_res == '0);
        err_d    = sc_err;
      end
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - CW'(1);
      if (op_q == OP_MUL) begin
        acc_d = mul_acc;
        opa_d = mul_mc;
        opb_d = mul_mp;
      end else begin
        acc_d = div_rem;
        opa_d = div_quo;
      end
      if (last) begin
        result_d = fin_res;
        zero_d   = (fin_res == '0);
        err_d    = 1'b0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and random checks of alu_mc (XLEN=32)
// against a queue-based behavioural model.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [3:0]  alu_control = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit prev_rst = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic        er;
    int          lat;
    int          acc;
    bit          seen;
  } exp_t;

  exp_t q[$];
  exp_t e_new;

  always #5 clk = ~clk;

  alu_mc #(.XLEN(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .src1(src1),
    .src2(src2),
    .alu_control(alu_control),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .zero(zero),
    .err(err)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    e.res  = '0;
    e.er   = 1'b0;
    e.acc  = 0;
    e.seen = 1'b0;
    e.lat  = (op >= 4'd10 && op <= 4'd12) ? 33 : 1;
    case (op)
      4'd0:  e.res = a + b;
      4'd1:  e.res = a - b;
      4'd2:  e.res = a & b;
      4'd3:  e.res = a | b;
      4'd4:  e.res = a ^ b;
      4'd5:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  e.res = a << b[4:0];
      4'd7:  e.res = a >> b[4:0];
      4'd8:  e.res = $signed(a) >>> b[4:0];
      4'd9:  e.res = (a < b) ? 32'd1 : 32'd0;
      4'd10: e.res = a * b;
      4'd11: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd12: e.res = (b == 0) ? a : a % b;
      default: e.er = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rnd();
    logic [31:0] v;
    case ($urandom % 4)
      0: v = $urandom;
      1: v = $urandom % 16;
      2: v = 32'h0;
      default: v = {1'b1, 31'($urandom)};
    endcase
    return v;
  endfunction

  // Compare process: every cycle, away from the rising edge
  always @(negedge clk) begin
    #2;
    cyc++;
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      prev_rst = 1'b0;
    end else begin
      if (q.size() == 0) begin
        chk("spurious_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, prev_rst ? 1 : 0);
      end else if (out_valid) begin
        if (!q[0].seen) begin
          chk("latency", cyc - q[0].acc, q[0].lat);
          q[0].seen = 1'b1;
        end
        chk("result", result, q[0].res);
        chk("err", err, q[0].er);
        chk("zero", zero, (q[0].res == 0));
        chk("done_in_ready", in_ready, out_ready);
      end else begin
        chk("busy_in_ready", in_ready, 0);
        if (cyc - q[0].acc >= q[0].lat) chk("late_out_valid", out_valid, 1);
      end
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        e_new = model(alu_control, src1, src2);
        e_new.acc = cyc;
        q.push_back(e_new);
      end
      prev_rst = 1'b1;
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    alu_control = op;
    src1 = a;
    src2 = b;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string name, input logic [31:0] exp_r,
                          input logic exp_e);
    int n;
    n = 0;
    #1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_valid"}, out_valid, 1);
    chk(name, result, exp_r);
    chk({name, "_err"}, err, exp_e);
    chk({name, "_zero"}, zero, (exp_r == 0));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_result", result, 0);
    chk("reset_zero", zero, 1);
    chk("reset_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    send(4'd0, 32'hFFFF_FFFF, 32'h1);
    wait_res("add_wrap", 32'h0, 1'b0);
    send(4'd5, 32'h8000_0000, 32'h1);
    wait_res("slt", 32'h1, 1'b0);
    send(4'd9, 32'h8000_0000, 32'h1);
    wait_res("sltu", 32'h0, 1'b0);
    send(4'd8, 32'h8000_0000, 32'd4);
    wait_res("sra", 32'hF800_0000, 1'b0);
    send(4'd7, 32'h8000_0000, 32'd4);
    wait_res("srl", 32'h0800_0000, 1'b0);
    send(4'd8, 32'h8765_4321, 32'd0);
    wait_res("sra_zero", 32'h8765_4321, 1'b0);
    send(4'd10, 32'h0001_0001, 32'h0001_0001);
    wait_res("mul", 32'h0002_0001, 1'b0);
    send(4'd11, 32'd100, 32'd7);
    wait_res("divu", 32'd14, 1'b0);
    send(4'd12, 32'd100, 32'd7);
    wait_res("remu", 32'd2, 1'b0);
    send(4'd11, 32'hDEAD_BEEF, 32'd0);
    wait_res("divu_by0", 32'hFFFF_FFFF, 1'b0);
    send(4'd12, 32'h1234, 32'd0);
    wait_res("remu_by0", 32'h1234, 1'b0);

    send(4'd0, 32'd10, 32'd20);
    send(4'd1, 32'd5, 32'd7);
    send(4'd4, 32'hF0F0_F0F0, 32'hFFFF_0000);
    repeat (3) @(negedge clk);

    out_ready = 1'b0;
    send(4'hF, 32'h1111, 32'h2222);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("illegal_result", result, 0);
      chk("illegal_err", err, 1);
      chk("illegal_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(4'd0, 32'd2, 32'd3);
    wait_res("add_after_illegal", 32'd5, 1'b0);

    send(4'd11, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    send(4'd0, 32'd1, 32'd1);
    wait_res("add_after_rst", 32'd2, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid = ($urandom % 3) != 0;
      out_ready = ($urandom % 4) != 0;
      alu_control = 4'($urandom % 16);
      src1 = rnd();
      src2 = rnd();
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(negedge clk);
    #3;
    chk("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
